fp_cmp_unit: RTL and testbench
==============================

Name: fp_cmp_unit

Overview:
- Parametrised, multi-cycle IEEE-754 comparator / min-max unit; successor to the fixed 32-bit single-cycle comparator.
- Supports any exponent/mantissa split, NaN classification (quiet vs signalling), signalling/quiet compare modes, MIN/MAX result, and a sticky invalid flag.
- Sits beside the FP datapath. It is started by `act` and reports results with a one-cycle `done` pulse.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa (fraction) width.
- Derived: W = 1+EXP_W+MAN_W, the operand width. Sign is bit W-1, exponent is [W-2:MAN_W], fraction is [MAN_W-1:0].

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- act  in  1  start request; sampled only in IDLE.
- op  in  2  00=CMP, 01=MIN, 10=MAX, 11=reserved (executes as CMP).
- sig  in  1  1=signalling compare: any NaN raises inv in CMP.
- in1  in  W  operand A.
- in2  in  W  operand B.
- clr_flags  in  1  clears inv_sticky.
- busy  out  1  high in CLASS and COMP states.
- done  out  1  one-cycle pulse when results are valid.
- eq  out  1  A == B (ordered).
- less  out  1  A < B.
- great  out  1  A > B.
- unord  out  1  at least one operand is NaN.
- inv  out  1  invalid-operation flag for this operation.
- inv_sticky  out  1  OR of inv since last clear.
- res  out  W  MIN/MAX result; 0 for CMP.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy, done, eq, less, great, unord, inv, inv_sticky = 0; res = 0. Reset in any state aborts the operation; no done is produced.
- FSM: IDLE -> CLASS -> COMP -> IDLE.
- IDLE: if act=1, register in1, in2, op and sig, then go to CLASS. If act=0, stay.
- CLASS: register classification flags per operand: zero, inf, NaN, sNaN, sign, magnitude {exp,frac}. Go to COMP.
- COMP: compute and register all result outputs; done=1 for exactly one cycle; go to IDLE.
- Latency: act sampled at edge N gives done=1 and valid results after edge N+2. Throughput is one operation per 3 cycles.
- act while busy is ignored (not queued). act during the done cycle is accepted, since the FSM is already in IDLE.
- Result outputs (eq, less, great, unord, inv, res) hold their value until the next done.
- Classification:
  - NaN: exp all-ones and frac != 0. sNaN: NaN with frac MSB = 0.
  - Inf: exp all-ones and frac = 0. Zero: exp = 0 and frac = 0.
  - Subnormals are ordered by raw magnitude (no flush).
- CMP ordering:
  - Either operand NaN: unord=1, eq=less=great=0.
  - Both zero (any signs): eq=1.
  - Signs differ: the negative operand is less.
  - Both positive: compare magnitude directly. Both negative: compare magnitude reversed.
  - Exactly one of eq, less, great, unord is 1 at done.
- MIN/MAX: flags eq/less/great/unord are computed as in CMP; res is selected as follows.
  - Any sNaN: res = canonical qNaN {0, all-ones exp, 1, zeros}.
  - Exactly one quiet NaN: res = the other operand.
  - Both quiet NaN: res = canonical qNaN.
  - +0 vs -0: MIN returns -0, MAX returns +0.
  - Otherwise MIN returns the lesser operand and MAX the greater.
- inv = 1 if any operand is sNaN (any op), or if op is CMP/reserved with sig=1 and any operand is NaN. Otherwise inv = 0.
- inv_sticky:
  - Set at the done cycle when inv=1.
  - Cleared when clr_flags=1.
  - If clr_flags coincides with a setting done, set wins.
  - clr_flags is honoured in every state.

Test Plan:
1. Default params, CMP with in1=3F800000, in2=40000000, act pulsed at edge N -> done=1 only after edge N+2; less=1, eq=great=unord=inv=0, res=0, busy=1 for 2 cycles.
2. in1=00000000, in2=80000000: CMP -> eq=1; MIN -> res=80000000; MAX -> res=00000000; inv=0 in all three.
3. in1=7FC00000, in2=3F800000: CMP with sig=0 -> unord=1, inv=0; CMP with sig=1 -> inv=1, inv_sticky=1; MIN -> res=3F800000, inv=0; clr_flags pulse -> inv_sticky=0.
4. in1=7F800001 (sNaN), in2=3F800000, MAX -> res=7FC00000, inv=1, unord=1. clr_flags asserted in the same done cycle -> inv_sticky=1 (set wins).
5. Sign ordering: C0000000 vs BF800000 CMP -> less=1; FF800000 vs 7F800000 -> less=1; 7F800000 vs FF800000 MAX -> res=7F800000.
6. Control:
   - act re-asserted while busy -> ignored, exactly one done.
   - act in the done cycle -> second done 3 cycles later.
   - rst in COMP -> no done, all outputs 0.
   - EXP_W=5, MAN_W=10: 3C00 vs 4000 -> less=1.

Source files
------------

// File: rtl/fp_cmp_unit.sv
// Parametrised IEEE-754 comparator and MIN/MAX unit. Three-state sequencer:
// IDLE captures operands, CLASS classifies them, COMP registers results and pulses done.
module fp_cmp_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         act,
  input  logic [1:0]   op,
  input  logic         sig,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic         clr_flags,
  output logic         busy,
  output logic         done,
  output logic         eq,
  output logic         less,
  output logic         great,
  output logic         unord,
  output logic         inv,
  output logic         inv_sticky,
  output logic [W-1:0] res
);

  typedef enum logic [1:0] {IDLE, CLASS, COMP} state_t;

  typedef struct packed {
    logic         zero;
    logic         nan;
    logic         snan;
    logic         sign;
    logic [W-2:0] mag;
  } cls_t;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic cls_t classify(input logic [W-1:0] x);
    cls_t c;
    logic exp_ones;
    logic frac_nz;
    exp_ones = &x[W-2:MAN_W];
    frac_nz  = |x[MAN_W-1:0];
    c.sign   = x[W-1];
    c.mag    = x[W-2:0];
    c.zero   = ~|x[W-2:0];
    c.nan    = exp_ones && frac_nz;
    c.snan   = c.nan && !x[MAN_W-1];
    return c;
  endfunction

  state_t       state_q, state_d;
  logic [W-1:0] a_q, b_q;
  logic [1:0]   op_q;
  logic         sig_q;
  cls_t         ca_q, cb_q;
  logic         done_q, eq_q, less_q, great_q, unord_q, inv_q, sticky_q, sticky_d;
  logic [W-1:0] res_q;

  logic         unord_c, eq_c, lt_raw, less_c, great_c, inv_c, is_cmp, is_min;
  logic [W-1:0] res_c;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (act) state_d = CLASS;
      CLASS:   state_d = COMP;
      COMP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ordering: negative sign loses; equal signs compare magnitude, reversed when negative.
  always_comb begin
    is_min  = (op_q == 2'b01);
    is_cmp  = !(is_min || (op_q == 2'b10));
    unord_c = ca_q.nan || cb_q.nan;
    eq_c    = !unord_c && ((ca_q.zero && cb_q.zero) || (a_q == b_q));
    if (ca_q.sign != cb_q.sign) lt_raw = ca_q.sign;
    else if (ca_q.sign)         lt_raw = (ca_q.mag > cb_q.mag);
    else                        lt_raw = (ca_q.mag < cb_q.mag);
    less_c  = !unord_c && !eq_c && lt_raw;
    great_c = !unord_c && !eq_c && !lt_raw;
    inv_c   = ca_q.snan || cb_q.snan || (is_cmp && sig_q && unord_c);
    res_c   = '0;
    if (!is_cmp) begin
      if (ca_q.snan || cb_q.snan || (ca_q.nan && cb_q.nan)) res_c = QNAN;
      else if (ca_q.nan)                res_c = b_q;
      else if (cb_q.nan)                res_c = a_q;
      else if (ca_q.zero && cb_q.zero)  res_c = (is_min == ca_q.sign) ? a_q : b_q;
      else if (is_min)                  res_c = less_c ? a_q : b_q;
      else                              res_c = great_c ? a_q : b_q;
    end
  end

  // A setting done beats a coincident clear, whether clear lands on the COMP edge or the done cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_flags) sticky_d = 1'b0;
    if (((state_q == COMP) && inv_c) || (done_q && inv_q)) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      eq_q     <= 1'b0;
      less_q   <= 1'b0;
      great_q  <= 1'b0;
      unord_q  <= 1'b0;
      inv_q    <= 1'b0;
      sticky_q <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= (state_q == COMP);
      sticky_q <= sticky_d;
      if (state_q == COMP) begin
        eq_q    <= eq_c;
        less_q  <= less_c;
        great_q <= great_c;
        unord_q <= unord_c;
        inv_q   <= inv_c;
        res_q   <= res_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && act) begin
      a_q   <= in1;
      b_q   <= in2;
      op_q  <= op;
      sig_q <= sig;
    end
    if (state_q == CLASS) begin
      ca_q <= classify(a_q);
      cb_q <= classify(b_q);
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign eq         = eq_q;
  assign less       = less_q;
  assign great      = great_q;
  assign unord      = unord_q;
  assign inv        = inv_q;
  assign inv_sticky = sticky_q;
  assign res        = res_q;

endmodule

// File: tb/tb_fp_cmp_unit.sv
// Bench for fp_cmp_unit: directed cases plus randomized operands checked against a
// real-valued reference model, on a default instance and a 5/10 half-precision instance.
module tb_fp_cmp_unit;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, act, sig, clr;
  logic [1:0]  op;
  logic [31:0] in1, in2, res;
  logic        busy, done, eq, less, great, unord, inv, inv_sticky;

  logic        s_act, s_sig, s_clr;
  logic [1:0]  s_op;
  logic [15:0] s_in1, s_in2, s_res;
  logic        s_busy, s_done, s_eq, s_less, s_great, s_unord, s_inv, s_inv_sticky;

  int   total = 0;
  int   bad   = 0;
  logic sticky_m;

  fp_cmp_unit dut (
    .clk(clk), .rst(rst), .act(act), .op(op), .sig(sig), .in1(in1), .in2(in2),
    .clr_flags(clr), .busy(busy), .done(done), .eq(eq), .less(less), .great(great),
    .unord(unord), .inv(inv), .inv_sticky(inv_sticky), .res(res)
  );

  fp_cmp_unit #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .act(s_act), .op(s_op), .sig(s_sig), .in1(s_in1), .in2(s_in2),
    .clr_flags(s_clr), .busy(s_busy), .done(s_done), .eq(s_eq), .less(s_less), .great(s_great),
    .unord(s_unord), .inv(s_inv), .inv_sticky(s_inv_sticky), .res(s_res)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fexp(input logic [31:0] x, input int ew, input int mw);
    return (x >> mw) & ((32'd1 << ew) - 32'd1);
  endfunction

  function automatic logic [31:0] ffrac(input logic [31:0] x, input int mw);
    return x & ((32'd1 << mw) - 32'd1);
  endfunction

  function automatic logic is_nan(input logic [31:0] x, input int ew, input int mw);
    return (fexp(x, ew, mw) == (32'd1 << ew) - 32'd1) && (ffrac(x, mw) != 0);
  endfunction

  function automatic logic is_snan(input logic [31:0] x, input int ew, input int mw);
    return is_nan(x, ew, mw) && (((x >> (mw - 1)) & 32'd1) == 0);
  endfunction

  // Numeric value of an encoding; infinities map to +-1e300, far beyond any finite operand.
  function automatic real fpval(input logic [31:0] x, input int ew, input int mw);
    int  e, bias;
    real f, v;
    bias = (1 << (ew - 1)) - 1;
    e    = int'(fexp(x, ew, mw));
    f    = real'(ffrac(x, mw));
    if (e == (1 << ew) - 1) v = 1.0e300;
    else if (e == 0)        v = f * 2.0 ** (1 - bias - mw);
    else                    v = (f + 2.0 ** mw) * 2.0 ** (e - bias - mw);
    return x[ew+mw] ? -v : v;
  endfunction

  // Returns {eq, less, great, unord, inv, res[31:0]}.
  function automatic logic [36:0] model(input logic [31:0] a, b, input logic [1:0] o,
                                        input logic s, input int ew, input int mw);
    logic na, nb, sa, sb, un, e_, l_, g_, iv;
    real  va, vb;
    logic [31:0] r, qn;
    na = is_nan(a, ew, mw);  nb = is_nan(b, ew, mw);
    sa = is_snan(a, ew, mw); sb = is_snan(b, ew, mw);
    va = fpval(a, ew, mw);   vb = fpval(b, ew, mw);
    un = na || nb;
    e_ = !un && (va == vb);
    l_ = !un && (va < vb);
    g_ = !un && (va > vb);
    iv = sa || sb || (((o == 2'd0) || (o == 2'd3)) && s && un);
    qn = (((32'd1 << ew) - 32'd1) << mw) | (32'd1 << (mw - 1));
    r  = 32'd0;
    if (o == 2'd1 || o == 2'd2) begin
      if (sa || sb || (na && nb)) r = qn;
      else if (na)                r = b;
      else if (nb)                r = a;
      else if (va == 0.0 && vb == 0.0) begin
        if (o == 2'd1) r = a[ew+mw] ? a : b;
        else           r = a[ew+mw] ? b : a;
      end
      else if (o == 2'd1) r = (va < vb) ? a : b;
      else                r = (va > vb) ? a : b;
    end
    return {e_, l_, g_, un, iv, r};
  endfunction

  function automatic logic [31:0] rnd_op(input int ew, input int mw);
    logic [31:0] em, fm, e, f, sg;
    em = (32'd1 << ew) - 32'd1;
    fm = (32'd1 << mw) - 32'd1;
    sg = $urandom & 32'd1;
    case ($urandom % 8)
      0:       begin e = $urandom & em; f = $urandom & fm; end
      1:       begin e = 0;  f = 0; end
      2:       begin e = em; f = 0; end
      3:       begin e = em; f = ($urandom & fm) | (32'd1 << (mw - 1)); end
      4:       begin e = em; f = ($urandom & (fm >> 1)) | 32'd1; end
      5:       begin e = 0;  f = $urandom & fm; end
      default: begin e = 32'd1 + ($urandom % (em - 32'd1)); f = $urandom & fm; end
    endcase
    return (sg << (ew + mw)) | (e << mw) | f;
  endfunction

  task automatic run0(input logic [31:0] a, b, input logic [1:0] o, input logic s, input bit now,
                      output logic [36:0] obs, output logic lat);
    if (!now) @(negedge clk);
    in1 = a; in2 = b; op = o; sig = s; act = 1'b1;
    @(negedge clk); act = 1'b0;
    lat = busy && !done;
    @(negedge clk); lat = lat && busy && !done;
    @(negedge clk); lat = lat && done && !busy;
    obs = {eq, less, great, unord, inv, res};
  endtask

  task automatic op0(input string tag, input logic [31:0] a, b, input logic [1:0] o,
                     input logic s, input bit now);
    logic [36:0] obs, exp;
    logic lat;
    run0(a, b, o, s, now, obs, lat);
    exp = model(a, b, o, s, 8, 23);
    chk({tag, "_lat"}, 64'(lat), 64'd1);
    chk(tag, 64'(obs), 64'(exp));
    if (exp[32]) sticky_m = 1'b1;
    chk({tag, "_stk"}, 64'(inv_sticky), 64'(sticky_m));
  endtask

  task automatic op1(input string tag, input logic [15:0] a, b, input logic [1:0] o, input logic s);
    logic [36:0] exp;
    logic lat;
    @(negedge clk);
    s_in1 = a; s_in2 = b; s_op = o; s_sig = s; s_act = 1'b1;
    @(negedge clk); s_act = 1'b0;
    lat = s_busy && !s_done;
    @(negedge clk); lat = lat && s_busy && !s_done;
    @(negedge clk); lat = lat && s_done && !s_busy;
    exp = model({16'h0, a}, {16'h0, b}, o, s, 5, 10);
    chk({tag, "_lat"}, 64'(lat), 64'd1);
    chk(tag, 64'({s_eq, s_less, s_great, s_unord, s_inv, 16'h0, s_res}), 64'(exp));
  endtask

  task automatic clr_pulse(input string tag);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    sticky_m = 1'b0;
    chk(tag, 64'(inv_sticky), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [36:0] exp;
    int ndone;
    rst = 1'b1; act = 1'b0; sig = 1'b0; clr = 1'b0; op = 2'd0; in1 = 0; in2 = 0;
    s_act = 1'b0; s_sig = 1'b0; s_clr = 1'b0; s_op = 2'd0; s_in1 = 0; s_in2 = 0;
    sticky_m = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out", 64'({busy, done, eq, less, great, unord, inv, inv_sticky, res}), 64'd0);
    chk("reset_h", 64'({s_busy, s_done, s_eq, s_less, s_great, s_unord, s_inv, s_inv_sticky, s_res}), 64'd0);
    rst = 1'b0;

    op0("t1_cmp", 32'h3F800000, 32'h40000000, 2'd0, 1'b0, 0);
    @(negedge clk);
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_hold", 64'({eq, less, great, unord, inv}), 64'b01000);

    op0("t2_cmp", 32'h00000000, 32'h80000000, 2'd0, 1'b0, 0);
    op0("t2_min", 32'h00000000, 32'h80000000, 2'd1, 1'b0, 0);
    op0("t2_max", 32'h00000000, 32'h80000000, 2'd2, 1'b0, 0);

    op0("t3_q", 32'h7FC00000, 32'h3F800000, 2'd0, 1'b0, 0);
    op0("t3_sig", 32'h7FC00000, 32'h3F800000, 2'd0, 1'b1, 0);
    op0("t3_min", 32'h7FC00000, 32'h3F800000, 2'd1, 1'b0, 0);
    clr_pulse("t3_clr");

    @(negedge clk);
    in1 = 32'h7F800001; in2 = 32'h3F800000; op = 2'd2; sig = 1'b0; act = 1'b1;
    @(negedge clk); act = 1'b0;
    @(negedge clk); clr = 1'b1;
    @(negedge clk);
    exp = model(32'h7F800001, 32'h3F800000, 2'd2, 1'b0, 8, 23);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_res", 64'({eq, less, great, unord, inv, res}), 64'(exp));
    chk("t4_stk_set", 64'(inv_sticky), 64'd1);
    @(negedge clk); clr = 1'b0;
    chk("t4_stk_win", 64'(inv_sticky), 64'd1);
    sticky_m = 1'b1;
    clr_pulse("t4_clr");

    op0("t5_neg", 32'hC0000000, 32'hBF800000, 2'd0, 1'b0, 0);
    op0("t5_inf", 32'hFF800000, 32'h7F800000, 2'd0, 1'b0, 0);
    op0("t5_max", 32'h7F800000, 32'hFF800000, 2'd2, 1'b0, 0);

    // act held through CLASS and COMP must not start a second operation.
    @(negedge clk);
    in1 = 32'h40400000; in2 = 32'hC0400000; op = 2'd1; sig = 1'b0; act = 1'b1;
    @(negedge clk); in1 = 32'h00000000;
    @(negedge clk);
    @(negedge clk); act = 1'b0;
    chk("t6_busy_done", 64'(done), 64'd1);
    chk("t6_busy_res", 64'({eq, less, great, unord, inv, res}),
        64'(model(32'h40400000, 32'hC0400000, 2'd1, 1'b0, 8, 23)));
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t6_one_done", 64'(ndone), 64'd0);

    op0("t6_first", 32'h3F800000, 32'h3F800000, 2'd0, 1'b0, 0);
    op0("t6_back2back", 32'h40000000, 32'h3F800000, 2'd0, 1'b0, 1);

    op0("t6_pre", 32'h7FC00000, 32'h00000000, 2'd0, 1'b1, 0);
    @(negedge clk);
    in1 = 32'h3F800000; in2 = 32'h40000000; op = 2'd0; act = 1'b1;
    @(negedge clk); act = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sticky_m = 1'b0;
    chk("t6_rst_out", 64'({busy, done, eq, less, great, unord, inv, inv_sticky, res}), 64'd0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t6_rst_nodone", 64'(ndone), 64'd0);

    op1("h_less", 16'h3C00, 16'h4000, 2'd0, 1'b0);
    op1("h_snan", 16'h7C01, 16'h3C00, 2'd2, 1'b0);
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ha, hb;
      ha = 16'(rnd_op(5, 10));
      case ($urandom % 4)
        0:       hb = ha;
        1:       hb = ha ^ 16'h8000;
        default: hb = 16'(rnd_op(5, 10));
      endcase
      op1($sformatf("h_rnd%0d", i), ha, hb, 2'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 300; i++) begin
      a = rnd_op(8, 23);
      case ($urandom % 4)
        0:       b = a;
        1:       b = a ^ 32'h80000000;
        default: b = rnd_op(8, 23);
      endcase
      if ($urandom % 16 == 0) clr_pulse($sformatf("rnd_clr%0d", i));
      op0($sformatf("rnd%0d", i), a, b, 2'($urandom), 1'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
